// File: rtl/key_filter_pkg.sv
// Shared constants for the key debouncer: FSM state codes, default timing
// values and the counter-width helper.
package key_filter_pkg;

  // 20 ms debounce window and 1 s long press at 50 MHz.
  localparam int unsigned CNT_MAX_DEF  = 999_999;
  localparam int unsigned LONG_MAX_DEF = 49_999_999;

  localparam logic [1:0] IDLE       = 2'd0;
  localparam logic [1:0] PRESS_FILT = 2'd1;
  localparam logic [1:0] DOWN       = 2'd2;
  localparam logic [1:0] REL_FILT   = 2'd3;

  // Bits needed to hold every value in 0..max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    int unsigned w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for asynchronous inputs; the reset value is a
// parameter so the output idles at the input's inactive level.
module sync_2ff #(
  parameter int unsigned           WIDTH   = 1,
  parameter logic [WIDTH-1:0]      RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  // NOTE: flops use non-blocking assignments so both stages sample the old
  // values on the same edge; blocking here would collapse the chain to one flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/key_filter.sv
// Push-button debouncer: single-cycle key_flag per confirmed press, debounced
// key_state level, and (with KEY_LONG_PRESS_EN defined) a one-shot long_flag.
module key_filter
  import key_filter_pkg::*;
#(
  parameter int unsigned CNT_MAX    = CNT_MAX_DEF,
  parameter logic        KEY_ACTIVE = 1'b0,
  parameter int unsigned LONG_MAX   = LONG_MAX_DEF
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_in,
  output logic key_flag,
  output logic key_state,
  output logic long_flag
);

`ifdef KEY_LONG_PRESS_EN
  // The counter must also hold the saturation value LONG_MAX+1.
  localparam int unsigned CW =
    cnt_width((CNT_MAX > LONG_MAX + 1) ? CNT_MAX : LONG_MAX + 1);
  localparam logic [CW-1:0] LONG_END = CW'(LONG_MAX);
  localparam logic [CW-1:0] LONG_SAT = CW'(LONG_MAX + 1);
`else
  localparam int unsigned CW = cnt_width(CNT_MAX);
`endif
  localparam logic [CW-1:0] CNT_END = CW'(CNT_MAX);

  logic          w_key_sync;
  logic          w_pressed;
  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_flag;
  logic          r_key_state;
  logic          r_long;

  sync_2ff #(
    .WIDTH   (1),
    .RST_VAL (~KEY_ACTIVE)
  ) u_sync (
    .clk   (sys_clk),
    .rst_n (sys_rst_n),
    .i_d   (key_in),
    .o_q   (w_key_sync)
  );

  assign w_pressed = (w_key_sync == KEY_ACTIVE);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_flag      <= 1'b0;
      r_key_state <= 1'b0;
      r_long      <= 1'b0;
    end else begin
      // NOTE: pulses default low every cycle and are raised only on the
      // transition edge, which makes them exactly one cycle wide.
      r_flag <= 1'b0;
      r_long <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_pressed) begin
            r_cnt   <= '0;
            r_state <= PRESS_FILT;
          end
        end
        PRESS_FILT: begin
          if (!w_pressed) begin
            r_cnt   <= '0;
            r_state <= IDLE;
          end else if (r_cnt == CNT_END) begin
            r_cnt       <= '0;
            r_flag      <= 1'b1;
            r_key_state <= 1'b1;
            r_state     <= DOWN;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DOWN: begin
          if (!w_pressed) begin
            r_cnt   <= '0;
            r_state <= REL_FILT;
`ifdef KEY_LONG_PRESS_EN
          end else if (r_cnt == LONG_END) begin
            r_long <= 1'b1;
            r_cnt  <= LONG_SAT;
          end else if (r_cnt != LONG_SAT) begin
            r_cnt <= r_cnt + 1'b1;
`else
          end else begin
            r_cnt <= '0;
`endif
          end
        end
        REL_FILT: begin
          if (w_pressed) begin
            r_cnt   <= '0;
            r_state <= DOWN;
          end else if (r_cnt == CNT_END) begin
            r_cnt       <= '0;
            r_key_state <= 1'b0;
            r_state     <= IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_cnt   <= '0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign key_flag  = r_flag;
  assign key_state = r_key_state;
  assign long_flag = r_long;

endmodule

// File: tb/tb_key_filter.sv
// Bench for key_filter: directed press/bounce/reset scenarios plus random key
// activity, all compared each cycle against an edge-counting reference model.
module tb_key_filter;

  localparam int CNT_MAX  = 9;
  localparam int LONG_MAX = 49;
  localparam int LAT      = CNT_MAX + 3;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;
  logic key_in    = 1'b1;
  logic key_flag;
  logic key_state;
  logic long_flag;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t_start;

  key_filter #(
    .CNT_MAX    (CNT_MAX),
    .KEY_ACTIVE (1'b0),
    .LONG_MAX   (LONG_MAX)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .key_in    (key_in),
    .key_flag  (key_flag),
    .key_state (key_state),
    .long_flag (long_flag)
  );

  always #10 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: the debounced level flips once the synchronized key has
  // disagreed with it for CNT_MAX+2 consecutive edges; a long press fires after
  // LONG_MAX+1 uninterrupted pressed edges following confirmation or resumption.
  logic [1:0] m_sync;
  logic       m_lvl, m_flag, m_long, m_prev_p;
  int         m_run, m_hold;

  always @(posedge sys_clk or negedge sys_rst_n) begin : ref_model
    logic p;
    if (!sys_rst_n) begin
      m_sync = 2'b11; m_lvl = 1'b0; m_flag = 1'b0; m_long = 1'b0;
      m_prev_p = 1'b0; m_run = 0; m_hold = 0;
    end else begin
      p      = (m_sync[1] == 1'b0);
      m_sync = {m_sync[0], key_in};
      m_flag = 1'b0;
      m_long = 1'b0;
      if (p != m_lvl) begin
        m_run++;
        if (m_run == CNT_MAX + 2) begin
          m_lvl  = p;
          m_run  = 0;
          m_flag = p;
          m_hold = 0;
        end
      end else begin
        m_run = 0;
        if (m_lvl) begin
          if (p && m_prev_p) m_hold++;
          else m_hold = 0;
`ifdef KEY_LONG_PRESS_EN
          if (m_hold == LONG_MAX + 1) m_long = 1'b1;
`endif
        end
      end
      m_prev_p = p;
    end
  end

  // Minimal bulk-erase front end: drops cs_n for a short burst per key_flag.
  logic cs_n;
  int   er_cnt;
  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cs_n   <= 1'b1;
      er_cnt <= 0;
    end else if (cs_n && key_flag) begin
      cs_n   <= 1'b0;
      er_cnt <= 3;
    end else if (!cs_n) begin
      if (er_cnt == 0) cs_n <= 1'b1;
      else er_cnt <= er_cnt - 1;
    end
  end

  int   n_flag = 0, n_long = 0, n_fall = 0, n_cs_fall = 0;
  int   last_flag_cyc = -1, last_long_cyc = -1, rise_cyc = -1, fall_cyc = -1;
  logic prev_state = 1'b0;
  logic prev_cs    = 1'b1;

  always @(negedge sys_clk) begin
    check("key_flag", key_flag, m_flag);
    check("key_state", key_state, m_lvl);
    check("long_flag", long_flag, m_long);
    check("flag_excl", key_flag & long_flag, 1'b0);
    if (key_flag) begin n_flag++; last_flag_cyc = cyc; end
    if (long_flag) begin n_long++; last_long_cyc = cyc; end
    if (key_state && !prev_state) rise_cyc = cyc;
    if (!key_state && prev_state) begin fall_cyc = cyc; n_fall++; end
    if (!cs_n && prev_cs) n_cs_fall++;
    prev_state = key_state;
    prev_cs    = cs_n;
  end

  // Holds key_in at v for n clock edges; t_start is the first edge sampling it.
  task automatic hold(input logic v, input int n);
    @(negedge sys_clk);
    key_in  = v;
    t_start = cyc + 1;
    repeat (n - 1) @(negedge sys_clk);
  endtask

  int k, rel, f0, l0, c0, fl0;

  initial begin
    repeat (3) @(negedge sys_clk);
    check("rst_flag", key_flag, 1'b0);
    check("rst_state", key_state, 1'b0);
    check("rst_long", long_flag, 1'b0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    hold(1'b1, 5);

    // Clean press and clean release
    f0 = n_flag;
    hold(1'b0, 40); k = t_start;
    hold(1'b1, 20); rel = t_start;
    check("clean_count", n_flag - f0, 1);
    check("clean_flag_at", last_flag_cyc, k + LAT);
    check("clean_rise_at", rise_cyc, k + LAT);
    check("clean_fall_at", fall_cyc, rel + LAT);

    // Press bounce: short low pulses, then a steady press
    f0 = n_flag;
    hold(1'b0, 3); hold(1'b1, 3);
    hold(1'b0, 5); hold(1'b1, 5);
    hold(1'b0, 8); hold(1'b1, 4);
    check("bounce_quiet", n_flag - f0, 0);
    hold(1'b0, 30); k = t_start;
    hold(1'b1, 20);
    check("bounce_count", n_flag - f0, 1);
    check("bounce_flag_at", last_flag_cyc, k + LAT);

    // Release bounce while held
    f0 = n_flag;
    hold(1'b0, 20);
    fl0 = n_fall;
    hold(1'b1, 6);
    hold(1'b0, 20);
    check("relb_state", key_state, 1'b1);
    check("relb_no_fall", n_fall - fl0, 0);
    check("relb_count", n_flag - f0, 1);
    hold(1'b1, 20); rel = t_start;
    check("relb_fall_at", fall_cyc, rel + LAT);

    // Long hold
    f0 = n_flag; l0 = n_long;
    hold(1'b0, 100); k = t_start;
    hold(1'b1, 20);
    check("long_key_count", n_flag - f0, 1);
`ifdef KEY_LONG_PRESS_EN
    check("long_count", n_long - l0, 1);
    check("long_at", last_long_cyc, k + LAT + LONG_MAX + 1);
`else
    check("long_count", n_long - l0, 0);
`endif

    // Reset in the middle of the press filter, key still held afterwards
    hold(1'b0, 8);
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    check("midrst_flag", key_flag, 1'b0);
    check("midrst_state", key_state, 1'b0);
    check("midrst_long", long_flag, 1'b0);
    f0 = n_flag;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    k = cyc + 1;
    repeat (20) @(negedge sys_clk);
    check("midrst_count", n_flag - f0, 1);
    check("midrst_flag_at", last_flag_cyc, k + LAT);
    hold(1'b1, 20);

    // Back-to-back presses feeding the erase front end
    f0 = n_flag; c0 = n_cs_fall;
    hold(1'b0, 20); hold(1'b1, 15);
    hold(1'b0, 20); hold(1'b1, 20);
    check("b2b_count", n_flag - f0, 2);
    check("b2b_cs_falls", n_cs_fall - c0, 2);

    // Random key activity against the model
    repeat (40) hold(1'($urandom_range(0, 1)), int'($urandom_range(1, 24)));
    hold(1'b1, 30);
    check("rand_released", key_state, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/key_filter.md
Name: key_filter

Overview:
- Debounces the raw board push-button and emits a clean single-cycle active-high trigger.
- Sits directly upstream of the flash command controllers (bulk/sector erase, page program); their key input consumes key_flag.
- Also exports the debounced level and, optionally, a long-press pulse.

Parameters:
- CNT_MAX, 999_999, debounce window in clock cycles minus one (20 ms at 50 MHz).
- KEY_ACTIVE, 1'b0, raw key level meaning "pressed" (board keys are active-low).
- LONG_MAX, 49_999_999, held-cycles threshold for a long press (1 s at 50 MHz); used only with the optional feature.

Ports:
- sys_clk  input  1  system clock, 50 MHz.
- sys_rst_n  input  1  asynchronous, active-low reset.
- key_in  input  1  raw, asynchronous, bouncing key level.
- key_flag  output  1  one-cycle high pulse on each confirmed press.
- key_state  output  1  debounced level, 1 = pressed.
- long_flag  output  1  one-cycle pulse on a confirmed long press.

Behaviour:
- Clock and reset: one clock, sys_clk. Reset sys_rst_n is asynchronous and active-low.
- Reset values:
  - Synchronizer flops reset to the released level (~KEY_ACTIVE).
  - key_flag=0, key_state=0, long_flag=0, cnt=0, state=IDLE.
- Synchronizer: 2 flops, key_in -> k1 -> k2. pressed = (k2 == KEY_ACTIVE).
- FSM states: IDLE, PRESS_FILT, DOWN, REL_FILT. cnt width = clog2 of max(CNT_MAX, LONG_MAX)+1.
- IDLE:
  - If pressed: cnt<=0, go to PRESS_FILT.
- PRESS_FILT:
  - If not pressed: go to IDLE, cnt<=0 (bounce rejected, no output).
  - Else if cnt==CNT_MAX: go to DOWN, key_flag<=1 for one cycle, key_state<=1, cnt<=0.
  - Else: cnt<=cnt+1.
- DOWN:
  - If not pressed: cnt<=0, go to REL_FILT.
  - Otherwise cnt counts; saturation rules are under Optional Feature.
- REL_FILT:
  - If pressed: return to DOWN, cnt<=0, no new key_flag.
  - Else if cnt==CNT_MAX: go to IDLE, key_state<=0.
  - Else: cnt<=cnt+1.
- Latency: clean press first sampled at edge k -> key_flag high from edge k+CNT_MAX+3 for exactly one cycle. Release uses the same latency for key_state falling.
- Exactly one key_flag per press, regardless of hold time or bounces during the hold.
- Bounce rules:
  - A bounce shorter than CNT_MAX+1 cycles in PRESS_FILT produces nothing.
  - A release bounce in REL_FILT does not retrigger.
- Reset mid-filter or mid-hold: all state clears at once, with no pulse on reset release. If the key is still held after reset release, the press is filtered afresh and flagged once.
- key_flag and long_flag are registered outputs and never both high in the same cycle.

Optional Feature:
- Macro: KEY_LONG_PRESS_EN.
- Defined:
  - In DOWN, cnt increments while pressed.
  - When cnt==LONG_MAX, long_flag<=1 for one cycle, then cnt saturates at LONG_MAX+1.
  - Only one long_flag per hold; the long_flag is in addition to the earlier key_flag.
- Undefined:
  - long_flag tied 0.
  - cnt held at 0 in DOWN.
  - cnt width sized from CNT_MAX only.

Decomposition:
- Package key_filter_pkg holds:
  - state typedef/localparams: IDLE=2'd0, PRESS_FILT=2'd1, DOWN=2'd2, REL_FILT=2'd3;
  - default CNT_MAX and LONG_MAX constants;
  - a clog2 width helper.
- One natural sub-module, sync_2ff: a generic 2-flop synchronizer with reset value as a parameter, reused by other async inputs.

Test Plan:
All scenarios use CNT_MAX=9, LONG_MAX=49, KEY_ACTIVE=0 and a 20 ns clock.
- Clean press: key_in low at edge k, held 40 cycles -> key_flag high only at edge k+12; key_state rises at k+12; no further flags.
- Press bounce: key_in toggles low/high with pulses of 3, 5 and 8 cycles, then stays low -> no flag during the bounces; exactly one key_flag 12 cycles after the final falling edge.
- Release bounce: while in DOWN, key_in goes high for 6 cycles then low again -> key_state stays 1; no second key_flag. A later clean release drops key_state 12 cycles after the release edge.
- Long press (KEY_LONG_PRESS_EN defined): hold for 100 cycles -> key_flag at k+12; long_flag once, 50 cycles after entering DOWN; no repeats. With the macro undefined, long_flag stays 0.
- Reset mid-filter: assert sys_rst_n=0 during PRESS_FILT at cnt=5, release it with key still held -> all outputs 0 during reset; one key_flag 12 cycles after reset release.
- Back-to-back presses: two clean presses separated by a 15-cycle release -> exactly two key_flag pulses. This pulse train drives a bulk-erase controller in the same bench, whose cs_n must fall once per pulse.
